loba_div_seq: RTL and testbench

//  Sequential approximate unsigned divider; the inverse operation of the LOBA approximate multipliers.

---
 rtl/loba_div_seq.sv | 208 ++++++++++++++++++++
 tb/tb_loba_div_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/loba_div_seq.sv
// Sequential LOBA approximate divider: leading-one windows, restoring core, rescale.
// Define LOBA_DIV_SIGNED_EN for two's complement operands and quotient.
module loba_div_seq #(
  parameter int N = 16,
  parameter int K = 4,
  parameter int F = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         dbz
);

  localparam int QW = K + F;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(QW) + 1;
  localparam int WW = N + QW;

  typedef enum logic [2:0] {
    IDLE, NORM, ITER, DENORM, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [IW-1:0]  ka_q, ka_d;
  logic [IW-1:0]  kb_q, kb_d;
  logic [K-1:0]   bh_q, bh_d;
  logic [K-1:0]   rem_q, rem_d;
  logic [QW-1:0]  dv_q, dv_d;
  logic [QW-1:0]  qr_q, qr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic           dbz_q, dbz_d;
`ifdef LOBA_DIV_SIGNED_EN
  logic           sgn_q, sgn_d;
  logic           asgn_q, asgn_d;
  logic [N-1:0]   lim;
`endif

  logic [IW-1:0]  ka_n, kb_n;
  logic [K-1:0]   ah_n, bh_n;
  logic [K:0]     r;
  logic           ge;
  int             s_w;
  logic [WW-1:0]  wide;
  logic           ovf;
  logic [N-1:0]   mag;

  // Index of leading one, floored at K-1 so the window never underflows.
  function automatic logic [IW-1:0] lead_idx(input logic [N-1:0] x);
    lead_idx = IW'(K - 1);
    for (int i = K; i < N; i++)
      if (x[i]) lead_idx = IW'(i);
  endfunction

`ifdef LOBA_DIV_SIGNED_EN
  function automatic logic [N-1:0] absv(input logic [N-1:0] x);
    absv = x[N-1] ? ~x + N'(1) : x;
  endfunction
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign dbz       = dbz_q;

  always_comb begin
    ka_n = lead_idx(a_q);
    kb_n = lead_idx(b_q);
    ah_n = K'(a_q >> (ka_n - IW'(K - 1)));
    bh_n = K'(b_q >> (kb_n - IW'(K - 1)));
    r    = {rem_q, dv_q[QW-1]};
    ge   = (r >= {1'b0, bh_q});
    s_w  = int'(ka_q) - int'(kb_q) - F;
    wide = '0;
    if (s_w >= 0) wide = WW'(qr_q) << s_w;
    else          wide = WW'(qr_q) >> (-s_w);
    ovf  = |wide[WW-1:N];
    mag  = ovf ? '1 : wide[N-1:0];
`ifdef LOBA_DIV_SIGNED_EN
    lim  = sgn_q ? {1'b1, {(N-1){1'b0}}}
                 : {1'b0, {(N-1){1'b1}}};
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    bh_d    = bh_q;
    rem_d   = rem_q;
    dv_d    = dv_q;
    qr_d    = qr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
`ifdef LOBA_DIV_SIGNED_EN
    sgn_d   = sgn_q;
    asgn_d  = asgn_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = NORM;
`ifdef LOBA_DIV_SIGNED_EN
          a_d    = absv(a);
          b_d    = absv(b);
          sgn_d  = a[N-1] ^ b[N-1];
          asgn_d = a[N-1];
`else
          a_d    = a;
          b_d    = b;
`endif
        end
      end
      NORM: begin
        // A zero divisor skips the core but keeps the DENORM slot.
        if (b_q == '0) begin
          dbz_d   = 1'b1;
          state_d = DENORM;
        end else begin
          dbz_d   = 1'b0;
          ka_d    = ka_n;
          kb_d    = kb_n;
          bh_d    = bh_n;
          dv_d    = {ah_n, {F{1'b0}}};
          rem_d   = '0;
          qr_d    = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = K'(ge ? r - {1'b0, bh_q} : r);
        dv_d  = dv_q << 1;
        qr_d  = {qr_q[QW-2:0], ge};
        if (cnt_q == CW'(QW - 1)) state_d = DENORM;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      DENORM: begin
        state_d = DONE;
`ifdef LOBA_DIV_SIGNED_EN
        if (dbz_q)
          q_d = asgn_q ? {1'b1, {(N-1){1'b0}}}
                       : {1'b0, {(N-1){1'b1}}};
        else if (mag > lim)
          q_d = sgn_q ? ~lim + N'(1) : lim;
        else
          q_d = sgn_q ? ~mag + N'(1) : mag;
`else
        q_d = dbz_q ? '1 : mag;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      bh_q    <= '0;
      rem_q   <= '0;
      dv_q    <= '0;
      qr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
`ifdef LOBA_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      asgn_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      bh_q    <= bh_d;
      rem_q   <= rem_d;
      dv_q    <= dv_d;
      qr_q    <= qr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
`ifdef LOBA_DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      asgn_q  <= asgn_d;
`endif
    end
  end

endmodule

// File: tb/tb_loba_div_seq.sv
// Randomised self-checking bench for loba_div_seq against an arithmetic model.
module tb_loba_div_seq;
  localparam int N = 16;
  localparam int K = 4;
  localparam int F = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] q;
  logic         dbz;

  int n_chk = 0;
  int n_fail = 0;
  logic [N-1:0] last_q;
  logic         last_z;

  loba_div_seq #(.N(N), .K(K), .F(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint lobamag(input longint ma, input longint mb);
    longint ka, kb, t, ah, bh, qr, s;
    ka = 0; t = ma;
    while (t > 1) begin t = t / 2; ka++; end
    if (ka < K - 1) ka = K - 1;
    kb = 0; t = mb;
    while (t > 1) begin t = t / 2; kb++; end
    if (kb < K - 1) kb = K - 1;
    ah = ma / (longint'(1) << (ka - K + 1));
    bh = mb / (longint'(1) << (kb - K + 1));
    qr = (ah * (longint'(1) << F)) / bh;
    s  = ka - kb - F;
    if (s >= 0) return qr * (longint'(1) << s);
    return qr / (longint'(1) << (-s));
  endfunction

  task automatic model(input logic [N-1:0] ai, input logic [N-1:0] bi,
                       output logic [N-1:0] qe, output logic ze);
    longint m, lim;
`ifdef LOBA_DIV_SIGNED_EN
    longint sa, sb;
    bit neg;
    sa = ai[N-1] ? longint'(ai) - (longint'(1) << N) : longint'(ai);
    sb = bi[N-1] ? longint'(bi) - (longint'(1) << N) : longint'(bi);
    if (sb == 0) begin
      ze = 1'b1;
      qe = (sa < 0) ? N'(longint'(1) << (N - 1))
                    : N'((longint'(1) << (N - 1)) - 1);
      return;
    end
    ze  = 1'b0;
    neg = (sa < 0) != (sb < 0);
    m   = lobamag(sa < 0 ? -sa : sa, sb < 0 ? -sb : sb);
    lim = neg ? (longint'(1) << (N - 1)) : (longint'(1) << (N - 1)) - 1;
    if (m > lim) m = lim;
    qe = N'(neg ? -m : m);
`else
    if (bi == 0) begin
      ze = 1'b1;
      qe = '1;
      return;
    end
    ze  = 1'b0;
    m   = lobamag(longint'(ai), longint'(bi));
    lim = (longint'(1) << N) - 1;
    qe  = N'(m > lim ? lim : m);
`endif
  endtask

  task automatic do_op(input logic [N-1:0] ai, input logic [N-1:0] bi,
                       input int hold);
    logic [N-1:0] qe;
    logic ze;
    int n;
    model(ai, bi, qe, ze);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
      if (n > 100) begin
        chk("timeout", 32'd0, 32'd1);
        return;
      end
    end
    chk("latency", 32'(n), ze ? 32'd2 : 32'(K + F + 2));
    chk("q", 32'(q), 32'(qe));
    chk("dbz", 32'(dbz), 32'(ze));
    last_q = q;
    last_z = dbz;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_q", 32'(q), 32'(qe));
      chk("hold_v", {out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_take", {out_valid, in_ready}, 32'b01);
  endtask

  task automatic mid_reset();
    int seen;
    @(negedge clk);
    a = 16'd500; b = 16'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vr", {out_valid, in_ready}, 32'b01);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_out", 32'(seen), 32'd0);
  endtask

  initial begin
    #2;
    chk("reset", {in_ready, out_valid, dbz, q}, {3'b100, 16'h0});
    #20 rst_n = 1'b1;
    do_op(16'd100, 16'd10, 0);
`ifndef LOBA_DIV_SIGNED_EN
    chk("dir_100_10", 32'(last_q), 32'd9);
    do_op(16'hFFFF, 16'd1, 0);
    chk("dir_ffff_1", 32'(last_q), 32'hF000);
    do_op(16'd7, 16'd1, 0);
    chk("dir_7_1", 32'(last_q), 32'd7);
    do_op(16'd3, 16'd200, 0);
    chk("dir_3_200", 32'(last_q), 32'd0);
    do_op(16'd0, 16'd5, 0);
    chk("dir_0_5", 32'(last_q), 32'd0);
    do_op(16'd1234, 16'd0, 0);
    chk("dir_dbz", {last_z, last_q}, {1'b1, 16'hFFFF});
`else
    chk("dir_s100", 32'(last_q), 32'd9);
    do_op(16'hFF9C, 16'd10, 0);
    chk("dir_neg100", 32'(last_q), 32'hFFF7);
    do_op(16'hFFFB, 16'd0, 0);
    chk("dir_sdbz", {last_z, last_q}, {1'b1, 16'h8000});
    do_op(16'h8000, 16'hFFFF, 0);
`endif
    do_op(16'd100, 16'd10, 20);
    mid_reset();
    do_op(16'd100, 16'd10, 0);
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = N'($urandom);
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = N'($urandom_range(1, 15));
        2: ra = N'($urandom_range(0, 31));
        default: ;
      endcase
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
